// File: rtl/veggie_operand_collector.sv
// veggie_operand_collector: gathers vs1, vs2 and optional v0 mask through the single-outstanding
// veggie read port and presents them as one operand bundle over valid/ready.
module veggie_operand_collector #(
   parameter int NUM_ELEMENTS = 32,
   parameter int ELEM_W       = 16,
   parameter int VSEL_W       = 5
) (
   input  logic                           CLK,
   input  logic                           nRST,
   input  logic                           issue_valid,
   output logic                           issue_ready,
   input  logic [VSEL_W-1:0]              issue_vs1,
   input  logic [VSEL_W-1:0]              issue_vs2,
   input  logic [VSEL_W-1:0]              issue_vd,
   input  logic                           issue_masked,
   output logic                           rd_req,
   output logic [VSEL_W-1:0]              rd_sel,
   input  logic                           rd_gnt,
   input  logic                           rd_rvalid,
   input  logic [NUM_ELEMENTS*ELEM_W-1:0] rd_rdata,
   output logic                           op_valid,
   input  logic                           op_ready,
   output logic [NUM_ELEMENTS*ELEM_W-1:0] op_v1,
   output logic [NUM_ELEMENTS*ELEM_W-1:0] op_v2,
   output logic [NUM_ELEMENTS-1:0]        op_vmask,
   output logic [VSEL_W-1:0]              op_vd,
   output logic                           err_unexpected
);
   typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, REQM, WAITM, OUT} state_t;
   state_t state, next;
   logic [VSEL_W-1:0] vs1, vs2;
   logic masked;
   logic waiting;
   logic [NUM_ELEMENTS-1:0] mask_bits;

   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) state <= IDLE;
      else state <= next;

   always_comb begin
      next = state;
      case (state)
         IDLE:  next = issue_valid ? REQ1 : IDLE;
         REQ1:  next = rd_gnt ? WAIT1 : REQ1;
         WAIT1: next = !rd_rvalid ? WAIT1 : vs1 != vs2 ? REQ2 : masked ? REQM : OUT;
         REQ2:  next = rd_gnt ? WAIT2 : REQ2;
         WAIT2: next = !rd_rvalid ? WAIT2 : masked ? REQM : OUT;
         REQM:  next = rd_gnt ? WAITM : REQM;
         WAITM: next = rd_rvalid ? OUT : WAITM;
         OUT:   next = op_ready ? IDLE : OUT;
         default: next = IDLE;
      endcase
   end

   always_comb begin
      issue_ready = state == IDLE;
      rd_req      = state == REQ1 || state == REQ2 || state == REQM;
      rd_sel      = state == REQ1 ? vs1 : state == REQ2 ? vs2 : '0;
      op_valid    = state == OUT;
      waiting     = state == WAIT1 || state == WAIT2 || state == WAITM;
      mask_bits   = '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) mask_bits[i] = rd_rdata[i*ELEM_W];
   end

   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         vs1            <= '0;
         vs2            <= '0;
         masked         <= 1'b0;
         op_v1          <= '0;
         op_v2          <= '0;
         op_vmask       <= '0;
         op_vd          <= '0;
         err_unexpected <= 1'b0;
      end else begin
         if (state == IDLE && issue_valid) begin
            vs1    <= issue_vs1;
            vs2    <= issue_vs2;
            op_vd  <= issue_vd;
            masked <= issue_masked;
         end
         if (state == WAIT1 && rd_rvalid) begin
            op_v1 <= rd_rdata;
            if (vs1 == vs2) op_v2 <= rd_rdata;
         end
         if (state == WAIT2 && rd_rvalid) op_v2 <= rd_rdata;
         // mask is settled on the transition into OUT: from v0 if masked, else all lanes active
         if (next == OUT && state != OUT) op_vmask <= state == WAITM ? mask_bits : '1;
         if (rd_rvalid && !waiting) err_unexpected <= 1'b1;
      end
endmodule

// File: tb/tb_veggie_operand_collector.sv
// tb_veggie_operand_collector: directed scenarios with hand-computed expectations for the collector.
module tb_veggie_operand_collector;
   logic         CLK = 1'b0;
   logic         nRST = 1'b0;
   logic         issue_valid = 1'b0, issue_masked = 1'b0;
   logic [4:0]   issue_vs1 = '0, issue_vs2 = '0, issue_vd = '0;
   logic         issue_ready, rd_req, rd_gnt = 1'b0, rd_rvalid = 1'b0;
   logic [4:0]   rd_sel, op_vd;
   logic [511:0] rd_rdata = '0, op_v1, op_v2;
   logic         op_valid, op_ready = 1'b0, err_unexpected;
   logic [31:0]  op_vmask;
   int           compared = 0, mismatched = 0, handshakes = 0;

   veggie_operand_collector dut (
      .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_vs1(issue_vs1), .issue_vs2(issue_vs2), .issue_vd(issue_vd), .issue_masked(issue_masked),
      .rd_req(rd_req), .rd_sel(rd_sel), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
      .op_valid(op_valid), .op_ready(op_ready), .op_v1(op_v1), .op_v2(op_v2),
      .op_vmask(op_vmask), .op_vd(op_vd), .err_unexpected(err_unexpected)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) if (rd_req && rd_gnt) handshakes++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [511:0] ramp();
      logic [511:0] r;
      for (int i = 0; i < 32; i++) r[i*16 +: 16] = 16'(i);
      return r;
   endfunction

   function automatic logic [511:0] v0_pattern();
      logic [511:0] r;
      for (int i = 0; i < 32; i++) r[i*16 +: 16] = 16'(i & 1);
      return r;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d, input logic m);
      issue_vs1 = s1; issue_vs2 = s2; issue_vd = d; issue_masked = m; issue_valid = 1'b1;
      tick();
      issue_valid = 1'b0;
   endtask

   // act as veggie for one read: optional grant stall, then one-cycle response
   task automatic serve(input logic [4:0] sel, input logic [511:0] data, input int gdly);
      int n = 0;
      while (!rd_req && n < 20) begin tick(); n++; end
      compared++;
      if (rd_req !== 1'b1) begin mismatched++; $display("FAIL serve_timeout: rd_req=%b expected 1", rd_req); end
      compared++;
      if (rd_sel !== sel) begin mismatched++; $display("FAIL rd_sel: got %0d expected %0d", rd_sel, sel); end
      repeat (gdly) begin
         tick();
         compared++;
         if (rd_req !== 1'b1 || rd_sel !== sel) begin
            mismatched++; $display("FAIL rd_stall_stable: rd_req=%b rd_sel=%0d expected 1/%0d", rd_req, rd_sel, sel);
         end
      end
      rd_gnt = 1'b1;
      tick();
      rd_gnt = 1'b0; rd_rvalid = 1'b1; rd_rdata = data;
      tick();
      rd_rvalid = 1'b0;
   endtask

   task automatic check_out(input string name, input logic [511:0] v1, input logic [511:0] v2,
                            input logic [31:0] vm, input logic [4:0] vd);
      compared++;
      if (op_valid !== 1'b1 || op_v1 !== v1 || op_v2 !== v2 || op_vmask !== vm || op_vd !== vd) begin
         mismatched++;
         $display("FAIL %s: valid=%b v1=%h v2=%h vmask=%h vd=%0d expected 1 v1=%h v2=%h vmask=%h vd=%0d",
                  name, op_valid, op_v1[63:0], op_v2[63:0], op_vmask, op_vd, v1[63:0], v2[63:0], vm, vd);
      end
   endtask

   task automatic accept();
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0;
      compared++;
      if (op_valid !== 1'b0 || issue_ready !== 1'b1) begin
         mismatched++; $display("FAIL accept: op_valid=%b issue_ready=%b expected 0/1", op_valid, issue_ready);
      end
   endtask

   task automatic test_reset();
      #12;
      compared++;
      if (issue_ready !== 1'b1 || rd_req !== 1'b0 || rd_sel !== 5'd0 || op_valid !== 1'b0) begin
         mismatched++; $display("FAIL reset_ctrl: ready=%b req=%b sel=%0d valid=%b expected 1/0/0/0", issue_ready, rd_req, rd_sel, op_valid);
      end
      compared++;
      if (op_v1 !== '0 || op_v2 !== '0 || op_vmask !== '0 || op_vd !== '0 || err_unexpected !== 1'b0) begin
         mismatched++; $display("FAIL reset_data: vmask=%h vd=%0d err=%b expected all zero", op_vmask, op_vd, err_unexpected);
      end
      nRST = 1'b1;
      tick();
   endtask

   task automatic test_unmasked();
      issue(5'd4, 5'd9, 5'd1, 1'b0);
      serve(5'd4, ramp(), 0);
      serve(5'd9, {32{16'h3C00}}, 0);
      check_out("unmasked", ramp(), {32{16'h3C00}}, 32'hFFFFFFFF, 5'd1);
      accept();
   endtask

   task automatic test_same_reg();
      int h0 = handshakes;
      issue(5'd7, 5'd7, 5'd2, 1'b0);
      serve(5'd7, {32{16'h7777}}, 0);
      check_out("same_reg", {32{16'h7777}}, {32{16'h7777}}, 32'hFFFFFFFF, 5'd2);
      compared++;
      if (handshakes - h0 !== 1) begin mismatched++; $display("FAIL same_reg_reads: got %0d expected 1", handshakes - h0); end
      accept();
   endtask

   task automatic test_masked();
      issue(5'd5, 5'd6, 5'd3, 1'b1);
      serve(5'd5, {32{16'h1111}}, 0);
      serve(5'd6, {32{16'h2222}}, 0);
      serve(5'd0, v0_pattern(), 0);
      check_out("masked", {32{16'h1111}}, {32{16'h2222}}, 32'hAAAAAAAA, 5'd3);
      accept();
   endtask

   task automatic test_stall();
      issue(5'd10, 5'd11, 5'd4, 1'b0);
      serve(5'd10, {32{16'hA0A0}}, 3);
      serve(5'd11, {32{16'hB1B1}}, 0);
      repeat (4) begin
         check_out("out_stall", {32{16'hA0A0}}, {32{16'hB1B1}}, 32'hFFFFFFFF, 5'd4);
         compared++;
         if (issue_ready !== 1'b0) begin mismatched++; $display("FAIL out_stall_ready: got %b expected 0", issue_ready); end
         tick();
      end
      accept();
   endtask

   task automatic test_back_to_back();
      issue_vs1 = 5'd12; issue_vs2 = 5'd13; issue_vd = 5'd5; issue_masked = 1'b0; issue_valid = 1'b1;
      tick();
      issue_vs1 = 5'd14; issue_vs2 = 5'd15; issue_vd = 5'd8;
      serve(5'd12, {32{16'hAAAA}}, 0);
      serve(5'd13, {32{16'hBBBB}}, 0);
      check_out("b2b_first", {32{16'hAAAA}}, {32{16'hBBBB}}, 32'hFFFFFFFF, 5'd5);
      compared++;
      if (issue_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_ready_out: got %b expected 0", issue_ready); end
      accept();
      tick();
      issue_valid = 1'b0;
      compared++;
      if (rd_req !== 1'b1 || rd_sel !== 5'd14) begin
         mismatched++; $display("FAIL b2b_second_accept: req=%b sel=%0d expected 1/14", rd_req, rd_sel);
      end
      serve(5'd14, {32{16'hCCCC}}, 0);
      serve(5'd15, {32{16'hDDDD}}, 0);
      check_out("b2b_second", {32{16'hCCCC}}, {32{16'hDDDD}}, 32'hFFFFFFFF, 5'd8);
      accept();
   endtask

   task automatic test_reset_midop();
      issue(5'd2, 5'd3, 5'd6, 1'b0);
      serve(5'd2, {32{16'h2020}}, 0);
      rd_gnt = 1'b1;
      tick();
      rd_gnt = 1'b0;
      nRST = 1'b0;
      #1;
      compared++;
      if (issue_ready !== 1'b1 || rd_req !== 1'b0 || rd_sel !== 5'd0 || op_valid !== 1'b0 ||
          op_v1 !== '0 || op_v2 !== '0 || op_vmask !== '0 || op_vd !== '0 || err_unexpected !== 1'b0) begin
         mismatched++; $display("FAIL midop_reset: ready=%b req=%b valid=%b vd=%0d err=%b expected reset values",
                                issue_ready, rd_req, op_valid, op_vd, err_unexpected);
      end
      tick();
      nRST = 1'b1; rd_rvalid = 1'b1; rd_rdata = {32{16'h3030}};
      tick();
      rd_rvalid = 1'b0;
      compared++;
      if (err_unexpected !== 1'b1 || issue_ready !== 1'b1) begin
         mismatched++; $display("FAIL late_rvalid: err=%b ready=%b expected 1/1", err_unexpected, issue_ready);
      end
      repeat (3) tick();
      compared++;
      if (err_unexpected !== 1'b1) begin mismatched++; $display("FAIL err_sticky: got %b expected 1", err_unexpected); end
   endtask

   initial begin
      test_reset();
      test_unmasked();
      test_same_reg();
      test_masked();
      test_stall();
      test_back_to_back();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
